cfg_reg_file: RTL

CFG_REG_FILE -- requirements
Module: cfg_reg_file

---
 rtl/rf_pkg.sv | 32 +++
 rtl/rf_rd_pipe.sv | 50 +++++
 rtl/cfg_reg_file.sv | 109 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and parameter helpers for cfg_reg_file
package rf_pkg;

  // Default reset image is built wide enough for four registers of up to 128 bits;
  // the top casts it down (or zero-extends) to DEPTH*WIDTH.
  localparam int RF_DEF_BITS = 512;

  localparam logic [31:0] RF_REG2_RST = 32'h0000_0081;
  localparam logic [31:0] RF_REG3_RST = 32'h0000_0020;

  // All registers reset to zero except reg2 and reg3, truncated to the register width.
  function automatic logic [RF_DEF_BITS-1:0] rf_default_rst_val(input int depth, input int width);
    logic [RF_DEF_BITS-1:0] v;
    logic [31:0]            m;
    v = '0;
    m = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    if (depth > 2) v = v | (RF_DEF_BITS'(RF_REG2_RST & m) << (2 * width));
    if (depth > 3) v = v | (RF_DEF_BITS'(RF_REG3_RST & m) << (3 * width));
    return v;
  endfunction

  // Read latency is a one- or two-stage delay line; anything else is unsupported.
  function automatic bit rf_rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit rf_geom_ok(input int depth, input int addr, input int num_cfg);
    return (depth >= 2) && (depth <= 256) && ((1 << addr) >= depth) &&
           (num_cfg >= 1) && (num_cfg <= depth);
  endfunction

endpackage

// File: rtl/rf_rd_pipe.sv
// rtl/rf_rd_pipe.sv - read data/valid/error delay line of RD_LAT stages
module rf_rd_pipe
  import rf_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_vld,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  if (!rf_rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("rf_rd_pipe: RD_LAT must be 1 or 2");
  end

  // Index 0 is the request being sampled; index RD_LAT is what the user sees.
  logic             vld_s  [RD_LAT+1];
  logic             err_s  [RD_LAT+1];
  logic [WIDTH-1:0] data_s [RD_LAT+1];

  assign vld_s[0]  = in_vld;
  assign err_s[0]  = in_err;
  assign data_s[0] = in_data;

  for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
    // Valid/error advance every cycle; data only moves with a valid, so the last stage holds.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        vld_s[s+1]  <= 1'b0;
        err_s[s+1]  <= 1'b0;
        data_s[s+1] <= '0;
      end else begin
        vld_s[s+1] <= vld_s[s];
        err_s[s+1] <= vld_s[s] & err_s[s];
        if (vld_s[s]) data_s[s+1] <= data_s[s];
      end
    end
  end

  assign out_vld  = vld_s[RD_LAT];
  assign out_err  = err_s[RD_LAT];
  assign out_data = data_s[RD_LAT];

endmodule

// File: rtl/cfg_reg_file.sv
// rtl/cfg_reg_file.sv - configuration register file with exported low registers
module cfg_reg_file
  import rf_pkg::*;
#(
  parameter int                     WIDTH   = 8,
  parameter int                     DEPTH   = 16,
  parameter int                     ADDR    = 4,
  parameter int                     NUM_CFG = 4,
  parameter int                     RD_LAT  = 1,
  parameter logic [DEPTH-1:0]       RO_MASK = '0,
  parameter logic [DEPTH*WIDTH-1:0] RST_VAL = (DEPTH*WIDTH)'(rf_default_rst_val(DEPTH, WIDTH))
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [ADDR-1:0]          Address,
  input  logic [WIDTH-1:0]         WrData,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_VLD,
  output logic                     RdErr,
  output logic                     WrErr,
  output logic [NUM_CFG*WIDTH-1:0] CFG_REGS,
  output logic [NUM_CFG-1:0]       CFG_UPD
);

  if (!rf_geom_ok(DEPTH, ADDR, NUM_CFG)) begin : g_bad_geom
    $error("cfg_reg_file: illegal DEPTH/ADDR/NUM_CFG combination");
  end

  // Read-only mask widened to the full address space so any Address indexes it safely.
  localparam logic [(1<<ADDR)-1:0] RO_EXT = ((1<<ADDR))'(RO_MASK);

  logic [WIDTH-1:0] regs   [DEPTH];
  logic [WIDTH-1:0] rd_tbl [1<<ADDR];
  logic             addr_in_range;
  logic             wr_ok;
  logic             wr_rej;
  logic             rd_in_err;
  logic [WIDTH-1:0] rd_in_data;
  logic             wr_err_q;

  assign addr_in_range = ({1'b0, Address} < (ADDR+1)'(DEPTH));
  assign wr_ok         = WrEn && addr_in_range && !RO_EXT[Address];
  assign wr_rej        = WrEn && !(addr_in_range && !RO_EXT[Address]);

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    logic             hit;
    logic [WIDTH-1:0] q;

    assign hit     = wr_ok && (Address == ADDR'(g));
    assign regs[g] = q;

    // Register storage: reset image on RST, new data on an accepted write to this index.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)     q <= RST_VAL[g*WIDTH +: WIDTH];
      else if (hit) q <= WrData;
    end

    if (g < NUM_CFG) begin : g_cfg
      logic upd_q;

      assign CFG_REGS[g*WIDTH +: WIDTH] = q;
      assign CFG_UPD[g]                 = upd_q;

      // Update strobe lines up with the new value: only a write that actually changes q.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) upd_q <= 1'b0;
        else      upd_q <= hit && (WrData != q);
      end
    end
  end

  // Holes above DEPTH read as zero so the read mux is a plain full-range index.
  for (genvar g = 0; g < (1<<ADDR); g++) begin : g_tbl
    if (g < DEPTH) begin : g_in
      assign rd_tbl[g] = regs[g];
    end else begin : g_out
      assign rd_tbl[g] = '0;
    end
  end

  // Read samples storage before this edge's write, giving read-before-write on collisions.
  assign rd_in_data = RdEn ? rd_tbl[Address] : '0;
  assign rd_in_err  = RdEn && !addr_in_range;

  // Rejected write is flagged one cycle later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wr_err_q <= 1'b0;
    else      wr_err_q <= wr_rej;
  end

  assign WrErr = wr_err_q;

  rf_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .CLK      (CLK),
    .RST      (RST),
    .in_vld   (RdEn),
    .in_err   (rd_in_err),
    .in_data  (rd_in_data),
    .out_vld  (RdData_VLD),
    .out_err  (RdErr),
    .out_data (RdData)
  );

endmodule
